// File: rtl/rb_toi2s_regbank.sv
// rb_toi2s_regbank: shadowed config register bank for the toi2s path.
// Config words are written into shadow registers over a valid/ready bus.
// A commit copies all of them to the active outputs in one cycle. A commit is
// either a software COMMIT or an I2S frame strobe while AUTO_COMMIT is set.
// Also holds a read-only live status word and a sticky W1C flag word.
// Optional macro TOI2S_RB_LOCK_EN adds a set-only LOCK bit (ctrl bit2).
module rb_toi2s_regbank #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = {NUM_REGS*DATA_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic                       frame_strobe_i,
  input  logic [DATA_W-1:0]          status_i,
  input  logic [DATA_W-1:0]          flag_i,
  output logic [NUM_REGS*DATA_W-1:0] cfg_o,
  output logic                       pending_o
);

  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] A_FLAG = ADDR_W'(NUM_REGS + 1);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_REGS + 2);

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] bank_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  bank_t             shadow, active;
  rsp_t              rsp_q, rsp_d;
  logic [DATA_W-1:0] sticky, w1c;
  logic              pending;
  logic              auto_q, auto_we;
  logic              lock_q;
  logic              acc, cfg_we, ctrl_we, commit;

  assign req_ready = !rsp_q.vld;
  assign acc       = req_valid && req_ready;
  assign rsp_valid = rsp_q.vld;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign cfg_o     = active;
  assign pending_o = pending;
  // The frame strobe looks at the AUTO_COMMIT value from before this cycle's write.
  assign commit    = (ctrl_we && req_wdata[0]) || (frame_strobe_i && auto_q);

  // Decode the accepted request into write enables and the response it produces
  always_comb begin
    rsp_d   = '0;
    cfg_we  = 1'b0;
    ctrl_we = 1'b0;
    auto_we = 1'b0;
    w1c     = '0;
    if (acc) begin
      rsp_d.vld = 1'b1;
      if (req_addr < A_STAT) begin
        if (req_write) begin
          if (lock_q) rsp_d.err = 1'b1;
          else        cfg_we    = 1'b1;
        end else begin
          for (int i = 0; i < NUM_REGS; i++)
            if (req_addr == ADDR_W'(i)) rsp_d.rdata = shadow[i];
        end
      end else if (req_addr == A_STAT) begin
        if (req_write) rsp_d.err   = 1'b1;
        else           rsp_d.rdata = status_i;
      end else if (req_addr == A_FLAG) begin
        if (req_write) w1c         = req_wdata;
        else           rsp_d.rdata = sticky;
      end else if (req_addr == A_CTRL) begin
        if (req_write) begin
          ctrl_we = 1'b1;
          // Locked: AUTO_COMMIT is frozen, but COMMIT in the same write still fires.
          if (lock_q && (req_wdata[1] != auto_q)) rsp_d.err = 1'b1;
          else                                    auto_we   = 1'b1;
        end else begin
          rsp_d.rdata[1] = auto_q;
          rsp_d.rdata[2] = lock_q;
        end
      end else begin
        rsp_d.err = 1'b1;
      end
    end
  end

  // Response register: loads on accept, holds until consumed
  always_ff @(posedge clk) begin
    if (!rst_n)                        rsp_q <= '0;
    else if (acc)                      rsp_q <= rsp_d;
    else if (rsp_q.vld && rsp_ready)   rsp_q <= '0;
  end

  // Shadow/active bank. A commit always takes the pre-write shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= bank_t'(RST_VAL);
      active  <= bank_t'(RST_VAL);
      pending <= 1'b0;
    end else begin
      if (commit) active <= shadow;
      for (int i = 0; i < NUM_REGS; i++)
        if (cfg_we && req_addr == ADDR_W'(i)) shadow[i] <= req_wdata;
      if (cfg_we)      pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  // Sticky flags: new set pulses win over a W1C in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) sticky <= '0;
    else        sticky <= (sticky & ~w1c) | flag_i;
  end

  // AUTO_COMMIT control bit
  always_ff @(posedge clk) begin
    if (!rst_n)       auto_q <= 1'b0;
    else if (auto_we) auto_q <= req_wdata[1];
  end

`ifdef TOI2S_RB_LOCK_EN
  // LOCK is set-only. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                       lock_q <= 1'b0;
    else if (ctrl_we && req_wdata[2]) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

endmodule

// File: tb/tb_rb_toi2s_regbank.sv
// Bench for rb_toi2s_regbank. A transaction-level model of the register map
// is checked against the DUT every cycle. Directed steps add literal checks.
module tb_rb_toi2s_regbank;
  localparam int N = 4;
  localparam logic [31:0] RST = 32'h0000_1A05;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic rsp_valid, rsp_ready = 1, rsp_err;
  logic [7:0] rsp_rdata;
  logic frame_strobe_i = 0;
  logic [7:0] status_i = 8'hA5, flag_i = '0;
  logic [31:0] cfg_o;
  logic pending_o;

  int errors = 0, checks = 0;

  rb_toi2s_regbank #(.NUM_REGS(N), .DATA_W(8), .ADDR_W(3), .RST_VAL(RST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .frame_strobe_i(frame_strobe_i), .status_i(status_i),
    .flag_i(flag_i), .cfg_o(cfg_o), .pending_o(pending_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: register map semantics on word arrays ----
  logic [7:0] m_sh[N], m_act[N];
  logic [7:0] m_sticky;
  logic m_pend, m_auto, m_lock, m_out, m_err, started = 0;
  logic [7:0] m_rd;

  function automatic logic [31:0] m_cfg();
    logic [31:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_act[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_sh[i] = RST[i*8 +: 8]; m_act[i] = RST[i*8 +: 8]; end
      m_sticky = 0; m_pend = 0; m_auto = 0; m_lock = 0; m_out = 0; m_rd = 0; m_err = 0;
      started = 1;
    end else begin
      automatic int a = int'(req_addr);
      automatic logic take = req_valid && !m_out;
      automatic logic do_commit = frame_strobe_i && m_auto;
      automatic logic [7:0] clr = 0, rd = 0;
      automatic logic er = 0;
      if (take && req_write && a == N + 2 && req_wdata[0]) do_commit = 1;
      if (do_commit) begin
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
        m_pend = 0;
      end
      if (take) begin
        if (a < N) begin
          if (!req_write) rd = m_sh[a];
          else if (m_lock) er = 1;
          else begin m_sh[a] = req_wdata; m_pend = 1; end
        end else if (a == N) begin
          if (req_write) er = 1; else rd = status_i;
        end else if (a == N + 1) begin
          if (req_write) clr = req_wdata; else rd = m_sticky;
        end else if (a == N + 2) begin
          if (!req_write) rd = {5'b0, m_lock, m_auto, 1'b0};
          else begin
            if (m_lock && req_wdata[1] != m_auto) er = 1;
            else m_auto = req_wdata[1];
`ifdef TOI2S_RB_LOCK_EN
            if (req_wdata[2]) m_lock = 1;
`endif
          end
        end else er = 1;
      end
      m_sticky = (m_sticky & ~clr) | flag_i;
      if (take) begin m_out = 1; m_rd = rd; m_err = er; end
      else if (m_out && rsp_ready) m_out = 0;
    end
  end

  // compare process: outputs against the model on every cycle
  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("cfg_o", cfg_o, m_cfg());
      chk("pending_o", {31'b0, pending_o}, {31'b0, m_pend});
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_out});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_out});
      if (m_out) begin
        chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, m_rd});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
      end
    end
  end

  // ---- stimulus helpers (always entered/left at posedge+#1) ----
  task automatic xact(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic sb, input logic [7:0] fl,
                      output logic [7:0] rd, output logic e);
    int n = 0;
    rsp_ready = 1;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    frame_strobe_i = sb; flag_i = fl;
    @(posedge clk); #1;
    req_valid = 0; frame_strobe_i = 0; flag_i = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_rdata; e = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, output logic e);
    logic [7:0] rd;
    xact(1'b1, a, d, 1'b0, 8'h00, rd, e);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] rd; logic e;
    xact(1'b0, a, 8'h00, 1'b0, 8'h00, rd, e);
    chk(name, {23'b0, e, rd}, {23'b0, 1'b0, exp});
  endtask

  task automatic strobe();
    frame_strobe_i = 1; @(posedge clk); #1; frame_strobe_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; repeat (3) @(posedge clk); #1; rst_n = 1;
  endtask

  logic e; logic [7:0] r;

  initial begin
    @(posedge clk); #1;
    do_reset();
    // reset state
    chk("rst_cfg", cfg_o, 32'h0000_1A05);
    chk("rst_pending", {31'b0, pending_o}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rd_chk("rd_addr1", 3'd1, 8'h1A);

    // shadowed write then software commit
    wr(3'd2, 8'hC3, e);
    chk("wr2_err", {31'b0, e}, 32'd0);
    chk("wr2_cfg_unchanged", cfg_o, 32'h0000_1A05);
    chk("wr2_pending", {31'b0, pending_o}, 32'd1);
    rd_chk("rd_addr2", 3'd2, 8'hC3);
    wr(3'd6, 8'h01, e);
    chk("commit_cfg", cfg_o, 32'h00C3_1A05);
    chk("commit_pending", {31'b0, pending_o}, 32'd0);
    rd_chk("rd_ctrl0", 3'd6, 8'h00);

    // auto-commit on frame strobe
    wr(3'd6, 8'h02, e);
    wr(3'd0, 8'h7F, e);
    chk("auto_pre", cfg_o, 32'h00C3_1A05);
    strobe();
    chk("auto_cfg", cfg_o, 32'h00C3_1A7F);
    rd_chk("rd_ctrl_auto", 3'd6, 8'h02);
    wr(3'd6, 8'h00, e);
    wr(3'd0, 8'h22, e);
    strobe();
    chk("noauto_cfg", cfg_o, 32'h00C3_1A7F);
    chk("noauto_pending", {31'b0, pending_o}, 32'd1);
    wr(3'd6, 8'h01, e);
    chk("commit2_cfg", cfg_o, 32'h00C3_1A22);

    // config write in the same cycle as a strobe commit
    wr(3'd6, 8'h02, e);
    wr(3'd1, 8'h33, e);
    xact(1'b1, 3'd3, 8'h55, 1'b1, 8'h00, r, e);
    chk("race_cfg", cfg_o, 32'h00C3_3322);
    chk("race_pending", {31'b0, pending_o}, 32'd1);
    wr(3'd6, 8'h01, e);
    chk("race_commit", cfg_o, 32'h55C3_3322);
    strobe();
    chk("harmless_strobe", cfg_o, 32'h55C3_3322);

    // sticky flags
    flag_i = 8'h05; @(posedge clk); #1; flag_i = 0;
    rd_chk("sticky_set", 3'd5, 8'h05);
    xact(1'b1, 3'd5, 8'h01, 1'b0, 8'h01, r, e);
    rd_chk("sticky_setwins", 3'd5, 8'h05);
    wr(3'd5, 8'h04, e);
    rd_chk("sticky_w1c", 3'd5, 8'h01);

    // status and error addresses
    rd_chk("status_a5", 3'd4, 8'hA5);
    status_i = 8'h3C;
    rd_chk("status_3c", 3'd4, 8'h3C);
    wr(3'd4, 8'hFF, e);
    chk("wr_status_err", {31'b0, e}, 32'd1);
    xact(1'b1, 3'd7, 8'hFF, 1'b0, 8'h00, r, e);
    chk("wr_bad_err", {23'b0, e, r}, {23'b0, 1'b1, 8'h00});
    xact(1'b0, 3'd7, 8'h00, 1'b0, 8'h00, r, e);
    chk("rd_bad_err", {23'b0, e, r}, {23'b0, 1'b1, 8'h00});
    chk("err_no_change", cfg_o, 32'h55C3_3322);
    rd_chk("rd_addr0_after_err", 3'd0, 8'h22);

    // backpressure: response held, second request blocked
    rsp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = 3'd1;
    @(posedge clk); #1;
    req_addr = 3'd2;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_rdata", {24'b0, rsp_rdata}, 32'h33);
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_drop", {31'b0, rsp_valid}, 32'd0);

    // lock bit
    wr(3'd6, 8'h04, e);
    wr(3'd0, 8'h11, e);
`ifdef TOI2S_RB_LOCK_EN
    chk("lock_wr_err", {31'b0, e}, 32'd1);
    rd_chk("lock_shadow", 3'd0, 8'h22);
    rd_chk("lock_ctrl", 3'd6, 8'h04);
    wr(3'd6, 8'h06, e);
    chk("lock_auto_err", {31'b0, e}, 32'd1);
    do_reset();
    rd_chk("lock_cleared", 3'd6, 8'h00);
`else
    chk("nolock_wr_err", {31'b0, e}, 32'd0);
    rd_chk("nolock_shadow", 3'd0, 8'h11);
    rd_chk("nolock_ctrl", 3'd6, 8'h00);
`endif

    // reset in the middle of a pending response
    wr(3'd3, 8'h99, e);
    rsp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = 3'd3;
    @(posedge clk); #1;
    req_valid = 0;
    do_reset();
    rsp_ready = 1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_cfg", cfg_o, 32'h0000_1A05);
    chk("midrst_pending", {31'b0, pending_o}, 32'd0);
    rd_chk("midrst_shadow3", 3'd3, 8'h00);
    rd_chk("midrst_sticky", 3'd5, 8'h00);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
